jk_cmd_driver: RTL

//  Upstream stimulus stage for the jk_ff cell. Accepts queued J/K commands over valid/ready,

---
 rtl/jk_pkg.sv | 26 ++
 rtl/jk_cmd_fifo.sv | 44 ++++
 rtl/jk_cmd_driver.sv | 120 ++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared opcodes, FSM state and command record for the J/K command driver
package jk_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic {IDLE, DRIVE} state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] len;
  } cmd_t;

  // Next q of a JK flop given its current j/k inputs.
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    case ({j, k})
      OP_CLR:  jk_next = 1'b0;
      OP_SET:  jk_next = 1'b1;
      OP_TOG:  jk_next = ~q;
      default: jk_next = q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// rtl/jk_cmd_fifo.sv - DEPTH x W synchronous FIFO, wrap-bit pointers, async active-high reset
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // Same slot but different lap means every entry is occupied.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/jk_cmd_driver.sv
// rtl/jk_cmd_driver.sv - queued J/K command driver for one jk_ff; JK_CHECK_EN adds the q/q_bar checker
module jk_cmd_driver
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_len,
  output logic             j,
  output logic             k,
  input  logic             q,
  input  logic             q_bar,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  cmd_t   push_cmd, head_cmd;
  logic   full, empty, pop;
  state_t state_q;
  logic   j_q, k_q, done_q;
  logic [3:0] rem_q;

  assign push_cmd = '{op: cmd_op, len: cmd_len};

  jk_cmd_fifo #(.DEPTH(DEPTH), .W(6)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd_valid),
    .data_i  (push_cmd),
    .pop_i   (pop),
    .data_o  (head_cmd),
    .full_o  (full),
    .empty_o (empty)
  );

  // The head is consumed whenever the FSM is free to start a command, including the
  // last drive cycle of the previous one so consecutive commands run without a gap.
  assign pop = !empty && ((state_q == IDLE) || (rem_q == 4'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      rem_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empty) begin
            j_q     <= head_cmd.op[1];
            k_q     <= head_cmd.op[0];
            rem_q   <= head_cmd.len;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          if (rem_q == 4'd0) begin
            done_q <= 1'b1;
            if (!empty) begin
              j_q   <= head_cmd.op[1];
              k_q   <= head_cmd.op[0];
              rem_q <= head_cmd.len;
            end else begin
              j_q     <= 1'b0;
              k_q     <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            rem_q <= rem_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = !full;
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = (state_q == DRIVE);
  assign done      = done_q;

`ifdef JK_CHECK_EN
  logic             exp_q_q, err_q, mismatch;
  logic [CNT_W-1:0] err_cnt_q;

  assign mismatch = (q != exp_q_q) || (q_bar != ~exp_q_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      exp_q_q <= jk_next(j_q, k_q, exp_q_q);
      err_q   <= mismatch;
      if (mismatch && (err_cnt_q != {CNT_W{1'b1}}))
        err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_q;
  assign unused_q = q ^ q_bar;
  assign err      = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule
